// File: rtl/axi_fsrc_sequencer_core_if.sv
// Control/status bundle between the FSRC register map and the sequencer timing core.
// The slave modport is the core's view; the master modport is the register map's view.
interface axi_fsrc_sequencer_core_if #(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4
);
    logic [31:0]                       seq_gpio_change_cnt;
    logic                              seq_start;
    logic                              seq_en;
    logic                              seq_ext_trig_en;
    logic                              ext_trig;
    logic [15:0]                       seq_tx_accum_reset_cnt;
    logic                              tx_non_fsrc_delay_en;
    logic [COUNTER_WIDTH-1:0]          seq_rx_delay_cnt;
    logic [CTRL_WIDTH-1:0]             dut_seq_gpio_w;
    logic [NUM_TRIG*COUNTER_WIDTH-1:0] first_trig_cnt;
    logic [NUM_TRIG*COUNTER_WIDTH-1:0] second_trig_cnt;
    logic [NUM_TRIG-1:0]               trig_out_en;
    logic [CTRL_WIDTH-1:0]             gpio_out;
    logic [NUM_TRIG-1:0]               trig_out;
    logic                              tx_accum_reset;
    logic                              rx_enable;
    logic                              busy;

    modport slave (
        input  seq_gpio_change_cnt, seq_start, seq_en, seq_ext_trig_en, ext_trig,
               seq_tx_accum_reset_cnt, tx_non_fsrc_delay_en, seq_rx_delay_cnt,
               dut_seq_gpio_w, first_trig_cnt, second_trig_cnt, trig_out_en,
        output gpio_out, trig_out, tx_accum_reset, rx_enable, busy
    );

    modport master (
        output seq_gpio_change_cnt, seq_start, seq_en, seq_ext_trig_en, ext_trig,
               seq_tx_accum_reset_cnt, tx_non_fsrc_delay_en, seq_rx_delay_cnt,
               dut_seq_gpio_w, first_trig_cnt, second_trig_cnt, trig_out_en,
        input  gpio_out, trig_out, tx_accum_reset, rx_enable, busy
    );
endinterface

// File: rtl/axi_fsrc_sequencer_core.sv
// FSRC sequencer timing engine: period counter, GPIO reload, trigger windows, TX accum reset, RX enable.
// Optional macro AXI_FSRC_SEQ_PERIOD_CNT_EN adds the saturating 32-bit period_cnt output.
module axi_fsrc_sequencer_core #(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4
) (
    input  logic clk,
    input  logic reset,
    axi_fsrc_sequencer_core_if.slave bus
`ifdef AXI_FSRC_SEQ_PERIOD_CNT_EN
    ,
    output logic [31:0] period_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   seq_start_dly_q, ext_trig_dly_q;
    logic   start_edge, ext_edge, run, wrap;

    logic [31:0]              per_cnt_q, per_cnt_d;
    logic                     load_q, load_d;
    logic [15:0]              period_num_q, period_num_d;
    logic                     acc_hit_q, acc_hit_d;
    logic                     tx_dly_q, tx_dly_d;
    logic                     tx_pulse_q, tx_pulse_d;
    logic [CTRL_WIDTH-1:0]    gpio_q, gpio_d;
    logic [COUNTER_WIDTH-1:0] phase_q, phase_d;
    logic                     phase_vld_q, phase_vld_d;
    logic                     phase_fresh_q, phase_fresh_d;
    logic [COUNTER_WIDTH-1:0] rx_dly_q, rx_dly_d;
    logic                     rx_en_q, rx_en_d;
    logic [NUM_TRIG-1:0]      trig_q, trig_d;
    logic [COUNTER_WIDTH-1:0] first_a  [NUM_TRIG];
    logic [COUNTER_WIDTH-1:0] second_a [NUM_TRIG];

    for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig_fields
        assign first_a[g]  = bus.first_trig_cnt[g*COUNTER_WIDTH +: COUNTER_WIDTH];
        assign second_a[g] = bus.second_trig_cnt[g*COUNTER_WIDTH +: COUNTER_WIDTH];
    end

    assign start_edge = bus.seq_start & ~seq_start_dly_q;
    assign ext_edge   = bus.ext_trig & ~ext_trig_dly_q;
    // Datapath only advances in RUN; the entry edge and any seq_en=0 cycle load zeros.
    assign run        = (state_q == ST_RUN) && bus.seq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.seq_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_edge) state_d = bus.seq_ext_trig_en ? ST_ARMED : ST_RUN;
                ST_ARMED: if (ext_edge) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    always_comb begin
        wrap          = 1'b0;
        per_cnt_d     = '0;
        load_d        = 1'b0;
        period_num_d  = '0;
        acc_hit_d     = 1'b0;
        tx_dly_d      = 1'b0;
        tx_pulse_d    = 1'b0;
        gpio_d        = '0;
        phase_d       = '0;
        phase_vld_d   = 1'b0;
        phase_fresh_d = 1'b0;
        rx_dly_d      = '0;
        rx_en_d       = 1'b0;
        if (run) begin
            wrap         = (per_cnt_q == bus.seq_gpio_change_cnt);
            per_cnt_d    = wrap ? 32'd0 : per_cnt_q + 32'd1;
            load_d       = wrap;
            period_num_d = period_num_q + {15'd0, wrap};
            acc_hit_d    = wrap && ((period_num_q + 16'd1) == bus.seq_tx_accum_reset_cnt);
            tx_dly_d     = acc_hit_q & bus.tx_non_fsrc_delay_en;
            tx_pulse_d   = (acc_hit_q & ~bus.tx_non_fsrc_delay_en) | tx_dly_q;
            gpio_d       = load_q ? bus.dut_seq_gpio_w : gpio_q;
            phase_vld_d  = phase_vld_q | load_q;
            // phase_fresh marks a newly reached phase value, so a saturated phase cannot re-fire a pulse.
            if (load_q) begin
                phase_d       = '0;
                phase_fresh_d = 1'b1;
            end else if (phase_vld_q && (phase_q != CNT_MAX)) begin
                phase_d       = phase_q + CNT_ONE;
                phase_fresh_d = 1'b1;
            end else begin
                phase_d       = phase_q;
                phase_fresh_d = 1'b0;
            end
            rx_dly_d = (rx_dly_q != CNT_MAX) ? rx_dly_q + CNT_ONE : rx_dly_q;
            rx_en_d  = rx_en_q | (rx_dly_q == bus.seq_rx_delay_cnt);
        end
    end

    always_comb begin
        trig_d = '0;
        if (run) begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                if (bus.trig_out_en[i] && phase_vld_q) begin
                    if (first_a[i] == second_a[i]) begin
                        trig_d[i] = phase_fresh_q && (phase_q == first_a[i]);
                    end else if (load_q && (second_a[i] < first_a[i])) begin
                        trig_d[i] = 1'b0;
                    end else if (phase_q == first_a[i]) begin
                        trig_d[i] = 1'b1;
                    end else if (phase_q == second_a[i]) begin
                        trig_d[i] = 1'b0;
                    end else begin
                        trig_d[i] = trig_q[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q          <= 1'b0;
            seq_start_dly_q <= 1'b0;
            ext_trig_dly_q  <= 1'b0;
            per_cnt_q       <= '0;
            load_q          <= 1'b0;
            period_num_q    <= '0;
            acc_hit_q       <= 1'b0;
            tx_dly_q        <= 1'b0;
            tx_pulse_q      <= 1'b0;
            gpio_q          <= '0;
            phase_q         <= '0;
            phase_vld_q     <= 1'b0;
            phase_fresh_q   <= 1'b0;
            rx_dly_q        <= '0;
            rx_en_q         <= 1'b0;
            trig_q          <= '0;
        end else begin
            busy_q          <= busy_d;
            seq_start_dly_q <= bus.seq_start;
            ext_trig_dly_q  <= bus.ext_trig;
            per_cnt_q       <= per_cnt_d;
            load_q          <= load_d;
            period_num_q    <= period_num_d;
            acc_hit_q       <= acc_hit_d;
            tx_dly_q        <= tx_dly_d;
            tx_pulse_q      <= tx_pulse_d;
            gpio_q          <= gpio_d;
            phase_q         <= phase_d;
            phase_vld_q     <= phase_vld_d;
            phase_fresh_q   <= phase_fresh_d;
            rx_dly_q        <= rx_dly_d;
            rx_en_q         <= rx_en_d;
            trig_q          <= trig_d;
        end
    end

`ifdef AXI_FSRC_SEQ_PERIOD_CNT_EN
    logic [31:0] period_cnt_q, period_cnt_d;

    always_comb begin
        period_cnt_d = '0;
        if (run) begin
            period_cnt_d = (wrap && (period_cnt_q != 32'hFFFF_FFFF)) ? period_cnt_q + 32'd1
                                                                     : period_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    assign bus.gpio_out       = gpio_q;
    assign bus.trig_out       = trig_q;
    assign bus.tx_accum_reset = tx_pulse_q;
    assign bus.rx_enable      = rx_en_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_axi_fsrc_sequencer_core.sv
// Directed plus randomized bench for axi_fsrc_sequencer_core against a cycle-index reference model.
// Honours AXI_FSRC_SEQ_PERIOD_CNT_EN when the optional period_cnt port is built.
module tb_axi_fsrc_sequencer_core;
    localparam int CW     = 40;
    localparam int NW     = 4;
    localparam int NT     = 4;
    localparam int PH_MAX = (1 << NW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_fsrc_sequencer_core_if #(.CTRL_WIDTH(CW), .COUNTER_WIDTH(NW), .NUM_TRIG(NT)) bus ();

`ifdef AXI_FSRC_SEQ_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    axi_fsrc_sequencer_core #(.CTRL_WIDTH(CW), .COUNTER_WIDTH(NW), .NUM_TRIG(NT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef AXI_FSRC_SEQ_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: m_st 0=idle 1=armed 2=run; t = clock edges since RUN entry.
    int          m_st;
    longint      t;
    logic        m_start_d, m_ext_d;
    logic [CW-1:0] exp_gpio;
    logic [NT-1:0] exp_trig;
    logic        exp_tx, exp_rx;
    logic [31:0] exp_pc;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", name, obs, exp, t);
        end
    endtask

    task automatic clear_exp();
        exp_gpio = '0;
        exp_trig = '0;
        exp_tx   = 1'b0;
        exp_rx   = 1'b0;
        exp_pc   = '0;
    endtask

    // A TX reset event happens at the reload edge of completed period k with k mod 2^16 == cnt.
    function automatic logic hit(input longint tl, input longint p, input logic [15:0] cnt);
        if (tl < p + 1 || ((tl - 1) % p) != 0) return 1'b0;
        return (((tl - 1) / p) % 65536) == longint'(cnt);
    endfunction

    task automatic tick();
        logic   se, ee;
        longint p;
        logic [NT-1:0] nt;
        se = bus.seq_start & ~m_start_d;
        ee = bus.ext_trig & ~m_ext_d;
        m_start_d = bus.seq_start;
        m_ext_d   = bus.ext_trig;
        p = longint'(bus.seq_gpio_change_cnt) + 1;
        if (reset || !bus.seq_en) begin
            if (reset) begin
                m_start_d = 1'b0;
                m_ext_d   = 1'b0;
            end
            m_st = 0;
            t    = -1;
            clear_exp();
        end else if (m_st == 0) begin
            if (se) begin
                m_st = bus.seq_ext_trig_en ? 1 : 2;
                t    = 0;
                clear_exp();
            end
        end else if (m_st == 1) begin
            if (ee) begin
                m_st = 2;
                t    = 0;
                clear_exp();
            end
        end else begin
            t++;
            if (t >= p + 1 && ((t - 1) % p) == 0) exp_gpio = bus.dut_seq_gpio_w;
            exp_rx = (t >= longint'(bus.seq_rx_delay_cnt) + 1);
            exp_tx = bus.tx_non_fsrc_delay_en ? hit(t - 1, p, bus.seq_tx_accum_reset_cnt)
                                              : hit(t, p, bus.seq_tx_accum_reset_cnt);
            exp_pc = 32'(t / p);
            for (int i = 0; i < NT; i++) begin
                int     f, s, ph;
                longint raw;
                f = int'(bus.first_trig_cnt[i*NW +: NW]);
                s = int'(bus.second_trig_cnt[i*NW +: NW]);
                if (!bus.trig_out_en[i] || (t - 1) < p + 1) begin
                    nt[i] = 1'b0;
                end else begin
                    raw = (t - 2) % p;
                    ph  = (raw > PH_MAX) ? PH_MAX : int'(raw);
                    if (f == s)                                nt[i] = (raw == longint'(f));
                    else if (((t - 1) % p) == 0 && s < f)      nt[i] = 1'b0;
                    else if (ph == f)                          nt[i] = 1'b1;
                    else if (ph == s)                          nt[i] = 1'b0;
                    else                                       nt[i] = exp_trig[i];
                end
            end
            exp_trig = nt;
        end
        @(posedge clk);
        #1;
        check("busy",           64'(bus.busy),           64'(m_st != 0));
        check("gpio_out",       64'(bus.gpio_out),       64'(exp_gpio));
        check("trig_out",       64'(bus.trig_out),       64'(exp_trig));
        check("tx_accum_reset", 64'(bus.tx_accum_reset), 64'(exp_tx));
        check("rx_enable",      64'(bus.rx_enable),      64'(exp_rx));
`ifdef AXI_FSRC_SEQ_PERIOD_CNT_EN
        check("period_cnt",     64'(period_cnt),         64'(exp_pc));
`endif
    endtask

    initial begin
        int            hi;
        logic [63:0]   r64;
        logic [CW-1:0] prev_w;

        reset = 1'b1;
        bus.seq_gpio_change_cnt    = '0;
        bus.seq_start              = 1'b0;
        bus.seq_en                 = 1'b0;
        bus.seq_ext_trig_en        = 1'b0;
        bus.ext_trig               = 1'b0;
        bus.seq_tx_accum_reset_cnt = '0;
        bus.tx_non_fsrc_delay_en   = 1'b0;
        bus.seq_rx_delay_cnt       = '0;
        bus.dut_seq_gpio_w         = '0;
        bus.first_trig_cnt         = '0;
        bus.second_trig_cnt        = '0;
        bus.trig_out_en            = '0;
        m_st = 0;
        t = -1;
        m_start_d = 1'b0;
        m_ext_d = 1'b0;
        clear_exp();
        tick();
        tick();
        reset = 1'b0;

        // No external trigger: reload timing, RX delay, accum reset at second boundary.
        bus.seq_en = 1'b1;
        bus.seq_gpio_change_cnt = 32'd9;
        bus.dut_seq_gpio_w = 40'hA5_0000_0001;
        bus.seq_rx_delay_cnt = 4'd5;
        bus.seq_tx_accum_reset_cnt = 16'd2;
        bus.seq_start = 1'b1;
        tick();
        check("busy_after_start", 64'(bus.busy), 64'd1);
        for (int c = 0; c < 35; c++) begin
            if (c == 15) bus.dut_seq_gpio_w = 40'h3C_1234_5678;
            tick();
            if (t == 5)  check("rx_before_delay", 64'(bus.rx_enable), 64'd0);
            if (t == 6)  check("rx_rise", 64'(bus.rx_enable), 64'd1);
            if (t == 10) check("gpio_before_load", 64'(bus.gpio_out), 64'd0);
            if (t == 11) check("gpio_first_load", 64'(bus.gpio_out), 64'hA5_0000_0001);
            if (t == 11) check("tx_first_boundary", 64'(bus.tx_accum_reset), 64'd0);
            if (t == 21) check("gpio_second_load", 64'(bus.gpio_out), 64'h3C_1234_5678);
            if (t == 21) check("tx_second_boundary", 64'(bus.tx_accum_reset), 64'd1);
`ifdef AXI_FSRC_SEQ_PERIOD_CNT_EN
            if (t == 20) check("period_cnt_two", 64'(period_cnt), 64'd2);
`endif
        end
        bus.seq_en = 1'b0;
        tick();
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_gpio", 64'(bus.gpio_out), 64'd0);
        check("abort_rx", 64'(bus.rx_enable), 64'd0);
        bus.seq_start = 1'b0;
        bus.seq_en = 1'b1;
        tick();

        // Trigger window 3..7 on channel 2, delayed accum reset, abort mid-window.
        bus.first_trig_cnt  = 16'h0300;
        bus.second_trig_cnt = 16'h0700;
        bus.trig_out_en = 4'b0100;
        bus.tx_non_fsrc_delay_en = 1'b1;
        bus.seq_rx_delay_cnt = 4'd0;
        bus.seq_start = 1'b1;
        tick();
        hi = 0;
        for (int c = 0; c < 36; c++) begin
            tick();
            if (t >= 11 && t <= 30 && bus.trig_out[2]) hi++;
            if (t == 15) check("trig2_window_start", 64'(bus.trig_out), 64'h4);
            if (t == 22) check("tx_delayed", 64'(bus.tx_accum_reset), 64'd1);
        end
        check("trig2_high_cycles", 64'(hi), 64'd8);
        check("trig2_mid_window", 64'(bus.trig_out[2]), 64'd1);
        bus.seq_en = 1'b0;
        tick();
        check("abort_trig", 64'(bus.trig_out), 64'd0);
        bus.seq_start = 1'b0;
        bus.seq_en = 1'b1;
        bus.tx_non_fsrc_delay_en = 1'b0;
        tick();

        // External arm: ext_trig high before start must not fire; a fresh rising edge does.
        bus.seq_ext_trig_en = 1'b1;
        bus.ext_trig = 1'b1;
        tick();
        bus.seq_start = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) tick();
        check("armed_busy", 64'(bus.busy), 64'd1);
        check("armed_gpio", 64'(bus.gpio_out), 64'd0);
        bus.ext_trig = 1'b0;
        tick();
        bus.ext_trig = 1'b1;
        tick();
        for (int c = 0; c < 14; c++) begin
            tick();
            if (t == 11) check("armed_gpio_load", 64'(bus.gpio_out), 64'(bus.dut_seq_gpio_w));
        end
        reset = 1'b1;
        tick();
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_gpio", 64'(bus.gpio_out), 64'd0);
        check("reset_trig", 64'(bus.trig_out), 64'd0);
        check("reset_rx", 64'(bus.rx_enable), 64'd0);
        reset = 1'b0;
        bus.seq_start = 1'b0;
        bus.seq_ext_trig_en = 1'b0;
        bus.ext_trig = 1'b0;
        tick();

        // One-cycle period: GPIO reloads every cycle.
        bus.seq_gpio_change_cnt = 32'd0;
        bus.first_trig_cnt  = 16'h0000;
        bus.second_trig_cnt = 16'h0000;
        bus.trig_out_en = 4'b0001;
        bus.seq_start = 1'b1;
        prev_w = bus.dut_seq_gpio_w;
        tick();
        for (int c = 0; c < 12; c++) begin
            prev_w = bus.dut_seq_gpio_w;
            tick();
            if (t >= 2) check("gpio_reload_every_cycle", 64'(bus.gpio_out), 64'(prev_w));
            r64 = {$urandom(), $urandom()};
            bus.dut_seq_gpio_w = r64[CW-1:0];
        end
        bus.seq_en = 1'b0;
        tick();
        bus.seq_start = 1'b0;
        bus.seq_en = 1'b1;
        tick();

        // first == second pulse on channel 1; second < first window on channel 0.
        bus.seq_gpio_change_cnt = 32'd9;
        bus.first_trig_cnt  = 16'h0036;
        bus.second_trig_cnt = 16'h0032;
        bus.trig_out_en = 4'b0011;
        bus.seq_start = 1'b1;
        tick();
        hi = 0;
        for (int c = 0; c < 35; c++) begin
            tick();
            if (t >= 11 && t <= 30 && bus.trig_out[1]) hi++;
            if (t == 21) check("late_window_cleared_at_boundary", 64'(bus.trig_out[0]), 64'd0);
        end
        check("pulse_count", 64'(hi), 64'd2);
        bus.seq_en = 1'b0;
        bus.seq_start = 1'b0;
        tick();
        bus.seq_en = 1'b1;
        tick();

        // Randomized runs against the model.
        for (int r = 0; r < 10; r++) begin
            bus.seq_gpio_change_cnt    = 32'($urandom_range(0, 11));
            bus.first_trig_cnt         = 16'($urandom());
            bus.second_trig_cnt        = 16'($urandom());
            bus.trig_out_en            = 4'($urandom_range(0, 15));
            bus.seq_rx_delay_cnt       = 4'($urandom_range(0, 15));
            bus.seq_tx_accum_reset_cnt = 16'($urandom_range(0, 4));
            bus.tx_non_fsrc_delay_en   = 1'($urandom_range(0, 1));
            bus.seq_ext_trig_en        = 1'($urandom_range(0, 1));
            bus.ext_trig               = 1'b0;
            bus.seq_start              = 1'b1;
            tick();
            for (int c = 0; c < 70; c++) begin
                r64 = {$urandom(), $urandom()};
                bus.dut_seq_gpio_w = r64[CW-1:0];
                if (bus.seq_ext_trig_en) bus.ext_trig = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) bus.trig_out_en = 4'($urandom_range(0, 15));
                tick();
            end
            bus.seq_en = 1'b0;
            bus.seq_start = 1'b0;
            bus.ext_trig = 1'b0;
            tick();
            bus.seq_en = 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
